// File: rtl/frame_addr_pkg.sv
// Shared types and width helpers for the frame address generator.
// Pure package: no logic, no latency, no flow control.
// Imported by frame_addr_gen and its delay-line sub-module.
package frame_addr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic longint total_pix(input int h, input int v, input int p);
        return longint'(h) * longint'(v) * longint'(p);
    endfunction

endpackage

// File: rtl/frame_addr_gen_lat_pipe.sv
// lat_pipe: WIDTH-bit shift register, DEPTH stages deep.
// Latency: dout follows din exactly DEPTH cycles later.
// No backpressure: shifts every cycle; clr empties all stages synchronously.
module lat_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_addr_gen.sv
// frame_addr_gen: plane/row-major BRAM read-address sweep with line/frame markers; FRAME_CNT_EN adds a completed-frame counter.
// Latency: addr_valid/line_end/frame_end combinational from state; rd_* strobes trail them by RD_LAT cycles.
// Backpressure: advance=0 holds all counters for any length of time; the rd_* delay line keeps shifting.
module frame_addr_gen
    import frame_addr_pkg::*;
#(
    parameter int H_PIX  = 256,
    parameter int V_PIX  = 256,
    parameter int PLANES = 3,
    parameter int ADDR_W = 18,
    parameter int RD_LAT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        continuous,
    input  logic                        abort,
    input  logic                        advance,
    output logic [ADDR_W-1:0]           addr,
    output logic [cnt_w(H_PIX)-1:0]     x,
    output logic [cnt_w(V_PIX)-1:0]     y,
    output logic [cnt_w(PLANES)-1:0]    plane,
    output logic                        addr_valid,
    output logic                        line_end,
    output logic                        frame_end,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_valid,
    output logic                        rd_line_end,
    output logic                        rd_frame_end,
    output logic [15:0]                 frame_cnt
);

    localparam int     X_W   = cnt_w(H_PIX);
    localparam int     Y_W   = cnt_w(V_PIX);
    localparam int     P_W   = cnt_w(PLANES);
    localparam longint TOTAL = total_pix(H_PIX, V_PIX, PLANES);

    if (TOTAL > (longint'(1) << ADDR_W)) begin : g_size_chk
        $error("frame_addr_gen: H_PIX*V_PIX*PLANES does not fit in ADDR_W bits");
    end

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [P_W-1:0]    plane_q, plane_d;
    logic              done_q, done_d;

    logic last_x, last_y, last_addr;

    assign last_x    = (x_q == X_W'(H_PIX - 1));
    assign last_y    = (y_q == Y_W'(V_PIX - 1));
    assign last_addr = (addr_q == ADDR_W'(TOTAL - 1));

    assign addr_valid = (state_q == RUN) && advance;
    assign line_end   = addr_valid && last_x;
    assign frame_end  = addr_valid && last_addr;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        plane_d = plane_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = continuous;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    plane_d = '0;
                end
            end
            RUN: begin
                if (advance) begin
                    if (last_addr) begin
                        // Wrap straight back to pixel 0; one-shot also drops to IDLE.
                        addr_d  = '0;
                        x_d     = '0;
                        y_d     = '0;
                        plane_d = '0;
                        if (!mode_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (last_x) begin
                            x_d = '0;
                            if (last_y) begin
                                y_d     = '0;
                                plane_d = plane_q + P_W'(1);
                            end else begin
                                y_d = y_q + Y_W'(1);
                            end
                        end else begin
                            x_d = x_q + X_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides start and advance, and never raises done.
        if (abort) begin
            state_d = IDLE;
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
            plane_d = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            plane_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            plane_q <= plane_d;
            done_q  <= done_d;
        end
    end

    assign addr  = addr_q;
    assign x     = x_q;
    assign y     = y_q;
    assign plane = plane_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;

    // Strobes ride one shared delay line so they stay aligned with BRAM dout.
    lat_pipe #(
        .WIDTH (3),
        .DEPTH (RD_LAT)
    ) u_lat_pipe (
        .clk   (clk),
        .reset (reset),
        .clr   (abort),
        .din   ({frame_end, line_end, addr_valid}),
        .dout  ({rd_frame_end, rd_line_end, rd_valid})
    );

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (frame_end) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule
